// File: rtl/crt_digit_seq_pkg.sv
// Shared constants and state type for the CRT digit sequencer.
package crt_pkg;
  localparam int unsigned RADIX_A = 3;
  localparam int unsigned RADIX_B = 5;
  localparam int unsigned NPTS    = 15;
  localparam int unsigned D3_W    = 2;
  localparam int unsigned D5_W    = 3;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/crt_digit_seq_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags an increment from MOD-1.
module mod_counter #(
  parameter int unsigned MOD = 3,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);
  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc)
      q_d = (q_q == TOP) ? '0 : q_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign wrap = inc && (q_q == TOP);
endmodule

// File: rtl/crt_digit_seq.sv
// CRT digit-pair sequencer: streams (n mod 3, n mod 5) for n=0..14, FRAMES frames per start.
// Optional CRT_SEQ_IDX_EN adds the natural index output idx.
module crt_digit_seq
  import crt_pkg::*;
#(
  parameter int unsigned FRAMES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ready,
  output logic            valid,
  output logic [D3_W-1:0] d3,
  output logic [D5_W-1:0] d5,
  output logic            last,
  output logic            busy,
  output logic            done
`ifdef CRT_SEQ_IDX_EN
  ,
  output logic [IDX_W-1:0] idx
`endif
);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

  seq_state_t         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               inc, clr, d3_wrap, d5_wrap, frame_end;

  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign clr   = valid && abort;
  assign inc   = valid && ready && !abort;
  // Both digits wrap on the same beat only at n=14; this also returns them to (0,0).
  assign frame_end = d3_wrap && d5_wrap;
  assign last  = (d3 == D3_W'(RADIX_A - 1)) && (d5 == D5_W'(RADIX_B - 1));

  mod_counter #(.MOD(RADIX_A), .W(D3_W)) u_cnt3 (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .q(d3), .wrap(d3_wrap)
  );

  mod_counter #(.MOD(RADIX_B), .W(D5_W)) u_cnt5 (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .q(d5), .wrap(d5_wrap)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        frame_d = '0;
        if (start && !abort) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          frame_d = '0;
        end else if (frame_end) begin
          if (frame_q == LAST_FRAME) begin
            state_d = DONE;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

`ifdef CRT_SEQ_IDX_EN
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (inc)
      idx_d = (idx_q == IDX_W'(NPTS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx = idx_q;
`endif
endmodule

// File: tb/tb_crt_digit_seq.sv
// Scoreboard bench for crt_digit_seq: one FRAMES=1 and one FRAMES=2 instance.
module tb_crt_digit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, abort = 1'b0, ready = 1'b0;

  logic v0, l0, b0, dn0, v1, l1, b1, dn1;
  logic [1:0] a0, a1;
  logic [2:0] c0, c1;
`ifdef CRT_SEQ_IDX_EN
  logic [3:0] ix0, ix1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int sb[$];
  logic running   = 1'b0;
  logic done_pend = 1'b0;
  int beats = 0;

  always #5 clk = ~clk;

  crt_digit_seq #(.FRAMES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .ready(ready),
    .valid(v0), .d3(a0), .d5(c0), .last(l0), .busy(b0), .done(dn0)
`ifdef CRT_SEQ_IDX_EN
    , .idx(ix0)
`endif
  );

  crt_digit_seq #(.FRAMES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .ready(ready),
    .valid(v1), .d3(a1), .d5(c1), .last(l1), .busy(b1), .done(dn1)
`ifdef CRT_SEQ_IDX_EN
    , .idx(ix1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Entry layout: [11:8]=n, [5]=last, [4:3]=d3, [2:0]=d5
  task automatic push_frames(input int nf);
    for (int f = 0; f < nf; f++)
      for (int n = 0; n < 15; n++)
        sb.push_back((n << 8) | ((n == 14 ? 1 : 0) << 5) | ((n % 3) << 3) | (n % 5));
  endtask

  task automatic start_run(input int sel, input int nf);
    sb.delete();
    push_frames(nf);
    ready = 1'b1;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    running = 1'b1;
    done_pend = 1'b0;
    beats = 0;
  endtask

  // Check the current cycle's outputs, then advance one clock with ready=rdy.
  task automatic cyc(input int sel, input logic rdy);
    logic v, l, b, dn;
    logic [1:0] a;
    logic [2:0] c;
    logic [3:0] ix;
    int e;
    ready = rdy;
    ix = 4'd0;
    if (sel == 0) begin
      v = v0; l = l0; b = b0; dn = dn0; a = a0; c = c0;
`ifdef CRT_SEQ_IDX_EN
      ix = ix0;
`endif
    end else begin
      v = v1; l = l1; b = b1; dn = dn1; a = a1; c = c1;
`ifdef CRT_SEQ_IDX_EN
      ix = ix1;
`endif
    end
    chk("valid", v, running);
    chk("busy", b, running);
    chk("done", dn, done_pend);
    done_pend = 1'b0;
    if (v && sb.size() > 0) begin
      e = sb[0];
      chk("d3", a, (e >> 3) & 3);
      chk("d5", c, e & 7);
      chk("last", l, (e >> 5) & 1);
`ifdef CRT_SEQ_IDX_EN
      chk("idx", ix, (e >> 8) & 15);
`endif
      if (rdy) begin
        void'(sb.pop_front());
        beats++;
        if (sb.size() == 0) begin
          running = 1'b0;
          done_pend = 1'b1;
        end
      end
    end else if (!running) begin
      chk("idle_d3", a, 0);
      chk("idle_d5", c, 0);
      chk("idle_last", l, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    running = 1'b0;
    done_pend = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", v0, 0); chk("rst_d3", a0, 0); chk("rst_d5", c0, 0);
    chk("rst_last", l0, 0); chk("rst_busy", b0, 0); chk("rst_done", dn0, 0);
    chk("rst_valid1", v1, 0); chk("rst_done1", dn1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 1'b1);

    // T1: single frame, ready held high
    start_run(0, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1'b1);
    chk("t1_beats", beats, 15);

    // T2: random ready
    start_run(0, 1);
    for (int i = 0; i < 300 && (running || done_pend); i++) cyc(0, 1'($urandom_range(0, 1)));
    cyc(0, 1'b1);
    chk("t2_beats", beats, 15);

    // T3: two frames back to back
    start_run(1, 2);
    for (int i = 0; i < 33; i++) cyc(1, 1'b1);
    chk("t3_beats", beats, 30);

    // T4: abort mid-run, then abort together with start in IDLE
    start_run(0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 1'b1);
    do_abort();
    cyc(0, 1'b1);
    cyc(0, 1'b1);
    start0 = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort = 1'b0;
    cyc(0, 1'b1);
    cyc(0, 1'b1);
    start_run(0, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1'b1);
    chk("t4_beats", beats, 15);

    // T5: start pulse during a run is ignored
    start_run(0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1'b1);
    start0 = 1'b1;
    cyc(0, 1'b1);
    start0 = 1'b0;
    for (int i = 0; i < 40 && (running || done_pend); i++) cyc(0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1);
    chk("t5_beats", beats, 15);

    // T6: asynchronous reset mid-frame while stalled
    start_run(0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1'b1);
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", v0, 0); chk("t6_d3", a0, 0); chk("t6_d5", c0, 0);
    chk("t6_last", l0, 0); chk("t6_busy", b0, 0); chk("t6_done", dn0, 0);
    sb.delete();
    running = 1'b0;
    done_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 1'b1);
    start_run(0, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1'b1);
    chk("t6_beats", beats, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
